// File: rtl/sat_pkg.sv
// Shared types for the SAT solver core: trail entry layout and trail FSM states.
`include "sysdefs.svh"

package sat_pkg;

    localparam int MAX_VARS    = `MAX_VARS;
    localparam int VAR_BITS    = `MAX_VARS_BITS;
    localparam int TRAIL_DBITS = `MAX_VARS_BITS + 1;

    // 'var' is a reserved word, so the variable index field is var_idx.
    typedef struct packed {
        logic [VAR_BITS-1:0] var_idx;
        logic                val;
        logic                decision;
    } trail_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } trail_state_e;

endpackage

// File: rtl/trail_stack_if.sv
// Controller <-> trail_stack bundle: push channel, backtrack request/result,
// var_state write port, occupancy status and the FSM state for observation.
interface trail_stack_if #(
    parameter int DBITS = sat_pkg::TRAIL_DBITS
) ();

    localparam int VB = sat_pkg::VAR_BITS;

    // Push handshake: an entry transfers on a clock edge where push_valid and
    // push_ready are both high. push_ready never depends on push_valid.
    logic                 push_valid;
    logic [VB-1:0]        push_var;
    logic                 push_val;
    logic                 push_decision;
    logic                 push_ready;

    logic                 bt_start;
    logic                 bt_done;
    logic                 bt_found;
    logic [VB-1:0]        bt_var;
    logic                 bt_val;

    logic                 vs_write;
    logic [VB-1:0]        vs_var;
    logic                 vs_val;
    logic                 vs_unassign;

    logic [DBITS-1:0]     depth;
    logic [DBITS-1:0]     level;
    logic                 full;
    logic                 empty;
    sat_pkg::trail_state_e state;

    modport master (
        output push_valid, push_var, push_val, push_decision, bt_start,
        input  push_ready, bt_done, bt_found, bt_var, bt_val,
        input  vs_write, vs_var, vs_val, vs_unassign,
        input  depth, level, full, empty, state
    );

    modport slave (
        input  push_valid, push_var, push_val, push_decision, bt_start,
        output push_ready, bt_done, bt_found, bt_var, bt_val,
        output vs_write, vs_var, vs_val, vs_unassign,
        output depth, level, full, empty, state
    );

endinterface

// File: rtl/sysdefs.svh
// System-wide sizing macros shared by the SAT solver core.
// Guarded so every file may include it regardless of compile order.
`ifndef SYSDEFS_SVH
`define SYSDEFS_SVH

`define MAX_VARS      16
`define MAX_VARS_BITS 4

`endif

// File: rtl/trail_ram.sv
// Trail storage: synchronous write, asynchronous read of the top-of-stack entry.
module trail_ram
    import sat_pkg::*;
#(
    parameter int DEPTH = sat_pkg::MAX_VARS,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  trail_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output trail_entry_t  o_rdata
);

    trail_entry_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail and backtrack engine: LIFO record of assignments mirrored to
// var_state, unwound one entry per cycle on conflict until a decision pops.
module trail_stack
    import sat_pkg::*;
#(
    parameter int DEPTH = sat_pkg::MAX_VARS,
    parameter int DBITS = sat_pkg::TRAIL_DBITS
) (
    input  logic          clock,
    input  logic          reset,
    trail_stack_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trail_state_e         r_state;
    logic [DBITS-1:0]     r_depth;
    logic [DBITS-1:0]     r_level;
    logic                 r_vs_write;
    logic [VAR_BITS-1:0]  r_vs_var;
    logic                 r_vs_val;
    logic                 r_vs_unassign;
    logic                 r_bt_done;
    logic                 r_bt_found;
    logic [VAR_BITS-1:0]  r_bt_var;
    logic                 r_bt_val;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ready;
    logic                 w_push_accept;
    logic [AW-1:0]        w_wr_addr;
    logic [AW-1:0]        w_rd_addr;
    trail_entry_t         w_wr_entry;
    trail_entry_t         w_top_entry;

    assign w_full        = (r_depth == DBITS'(DEPTH));
    assign w_empty       = (r_depth == '0);
    assign w_push_ready  = (r_state == IDLE) && !w_full && !bus.bt_start;
    assign w_push_accept = bus.push_valid && w_push_ready;

    // Writes land at the current depth; the top entry sits one below it.
    assign w_wr_addr = r_depth[AW-1:0];
    assign w_rd_addr = r_depth[AW-1:0] - AW'(1);

    assign w_wr_entry.var_idx  = bus.push_var;
    assign w_wr_entry.val      = bus.push_val;
    assign w_wr_entry.decision = bus.push_decision;

    trail_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_trail_ram (
        .clock   (clock),
        .i_we    (w_push_accept),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wr_entry),
        .i_raddr (w_rd_addr),
        .o_rdata (w_top_entry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_depth       <= '0;
            r_level       <= '0;
            r_vs_write    <= 1'b0;
            r_vs_var      <= '0;
            r_vs_val      <= 1'b0;
            r_vs_unassign <= 1'b0;
            r_bt_done     <= 1'b0;
            r_bt_found    <= 1'b0;
            r_bt_var      <= '0;
            r_bt_val      <= 1'b0;
        end else begin
            r_vs_write <= 1'b0;
            r_bt_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A backtrack request wins over a push offered in the same cycle.
                    if (bus.bt_start) begin
                        r_state <= POP;
                    end else if (w_push_accept) begin
                        r_depth       <= r_depth + DBITS'(1);
                        r_level       <= r_level + DBITS'(bus.push_decision);
                        r_vs_write    <= 1'b1;
                        r_vs_var      <= bus.push_var;
                        r_vs_val      <= bus.push_val;
                        r_vs_unassign <= 1'b0;
                    end
                end
                POP: begin
                    if (!w_empty) begin
                        r_depth       <= r_depth - DBITS'(1);
                        r_vs_write    <= 1'b1;
                        r_vs_var      <= w_top_entry.var_idx;
                        r_vs_val      <= 1'b0;
                        r_vs_unassign <= 1'b1;
                        if (w_top_entry.decision) begin
                            r_level    <= r_level - DBITS'(1);
                            r_bt_var   <= w_top_entry.var_idx;
                            r_bt_val   <= w_top_entry.val;
                            r_bt_found <= 1'b1;
                            r_bt_done  <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_bt_found <= 1'b0;
                        r_bt_done  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.push_ready  = w_push_ready;
    assign bus.bt_done     = r_bt_done;
    assign bus.bt_found    = r_bt_found;
    assign bus.bt_var      = r_bt_var;
    assign bus.bt_val      = r_bt_val;
    assign bus.vs_write    = r_vs_write;
    assign bus.vs_var      = r_vs_var;
    assign bus.vs_val      = r_vs_val;
    assign bus.vs_unassign = r_vs_unassign;
    assign bus.depth       = r_depth;
    assign bus.level       = r_level;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.state       = r_state;

    a_level_le_depth: assert property (@(posedge clock) disable iff (reset)
        r_level <= r_depth);
    a_depth_bounded: assert property (@(posedge clock) disable iff (reset)
        r_depth <= DBITS'(DEPTH));

endmodule
